// File: rtl/alu_flag_unit.sv
// Execute-stage ALU with registered result, N/Z/C/V flag register, condition evaluation and
// an optional iterative shift-add multiplier (enabled by defining ALU_MULT_EN).
module alu_flag_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [2:0]       ALUOp,
  input  logic             FU,
  input  logic [2:0]       CC,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ALUO,
  output logic [3:0]       Flags,
  output logic             Perform,
  output logic             Busy,
  output logic             Done
);
  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_SUB = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    CC_EQ = 3'b000,
    CC_NE = 3'b001,
    CC_LT = 3'b010,
    CC_GE = 3'b011,
    CC_CS = 3'b100,
    CC_CC = 3'b101,
    CC_MI = 3'b110,
    CC_AL = 3'b111
  } cc_t;

  logic [WIDTH-1:0] aluo_q, aluo_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   alu_wide;
  logic             alu_c, alu_v;
  logic [SW-1:0]    sh_amt;
  logic [3:0]       alu_flags;

  assign sh_amt    = b[SW-1:0];
  assign alu_flags = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};

  // Shifts run one bit wider than the datapath so the extra bit is the last bit shifted out.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_t'(ALUOp))
      OP_ADD: begin
        alu_wide = {1'b0, a} + {1'b0, b};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
        alu_v    = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_wide = {1'b0, a} - {1'b0, b};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = ~alu_wide[WIDTH];
        alu_v    = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLL: begin
        alu_wide = {1'b0, a} << sh_amt;
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_SRL: begin
        alu_wide = {a, 1'b0} >> sh_amt;
        alu_res  = alu_wide[WIDTH:1];
        alu_c    = alu_wide[0];
      end
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULT_EN
  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic               mfu_q, mfu_d;
  logic               hi_nz;

  assign Busy = (state_q == ST_RUN);
`else
  assign Busy = 1'b0;
`endif

  always_comb begin
    aluo_d  = aluo_q;
    flags_d = flags_q;
    done_d  = 1'b0;
`ifdef ALU_MULT_EN
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    mfu_d    = mfu_q;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    hi_nz    = (acc_sum[2*WIDTH-1:WIDTH] != '0);
    if (state_q == ST_RUN) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SW'(1);
      if (cnt_q == SW'(WIDTH - 1)) begin
        state_d = ST_IDLE;
        aluo_d  = acc_sum[WIDTH-1:0];
        done_d  = 1'b1;
        if (mfu_q) begin
          flags_d = {acc_sum[WIDTH-1], acc_sum[WIDTH-1:0] == '0, hi_nz, hi_nz};
        end
      end
    end else if (Valid) begin
      if (op_t'(ALUOp) == OP_MUL) begin
        state_d  = ST_RUN;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        cnt_d    = '0;
        mfu_d    = FU;
      end else begin
        aluo_d = alu_res;
        done_d = 1'b1;
        if (FU) begin
          flags_d = alu_flags;
        end
      end
    end
`else
    if (Valid) begin
      aluo_d = alu_res;
      done_d = 1'b1;
      if (FU) begin
        flags_d = alu_flags;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      aluo_q   <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
`ifdef ALU_MULT_EN
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mfu_q    <= 1'b0;
`endif
    end else begin
      aluo_q   <= aluo_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
`ifdef ALU_MULT_EN
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      mfu_q    <= mfu_d;
`endif
    end
  end

  always_comb begin
    Perform = 1'b1;
    case (cc_t'(CC))
      CC_EQ:   Perform = flags_q[2];
      CC_NE:   Perform = ~flags_q[2];
      CC_LT:   Perform = flags_q[3] ^ flags_q[0];
      CC_GE:   Perform = ~(flags_q[3] ^ flags_q[0]);
      CC_CS:   Perform = flags_q[1];
      CC_CC:   Perform = ~flags_q[1];
      CC_MI:   Perform = flags_q[3];
      default: Perform = 1'b1;
    endcase
  end

  assign ALUO  = aluo_q;
  assign Flags = flags_q;
  assign Done  = done_q;

endmodule
